// File: rtl/led_fade_pkg.sv
// Shared constants and types for the LED fade/PWM output stage.
package led_fade_pkg;

    localparam int NUM_LED      = 3;
    localparam int PWM_BITS_DEF = 8;

    typedef logic [PWM_BITS_DEF-1:0] level_t;

endpackage : led_fade_pkg

// File: rtl/led_fade_channel.sv
// One LED channel: brightness ramp, period-aligned duty latch and registered PWM compare.
module led_fade_channel
    import led_fade_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                reest,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    input  logic                i_step_tick,
    input  logic                i_period_end,
    input  logic [PWM_BITS-1:0] i_target,
    input  logic                i_fade_en,
    output logic [PWM_BITS-1:0] o_lvl,
    output logic                o_pwm
);

    logic [PWM_BITS-1:0] r_lvl;
    logic [PWM_BITS-1:0] r_duty;
    logic                r_pwm;
    logic [PWM_BITS-1:0] w_lvl_nxt;

    // Next brightness: snap when fading is off, else one saturating step toward target per tick.
    always_comb begin
        w_lvl_nxt = r_lvl;
        if (!i_fade_en) begin
            w_lvl_nxt = i_target;
        end else if (i_step_tick && (r_lvl < i_target)) begin
            w_lvl_nxt = r_lvl + {{(PWM_BITS-1){1'b0}}, 1'b1};
        end else if (i_step_tick && (r_lvl > i_target)) begin
            w_lvl_nxt = r_lvl - {{(PWM_BITS-1){1'b0}}, 1'b1};
        end else begin
            w_lvl_nxt = r_lvl;
        end
    end

    // Level, duty and PWM registers; duty only moves on the last count so no period is cut short.
    always_ff @(posedge clk) begin
        if (reest) begin
            r_lvl  <= {PWM_BITS{1'b0}};
            r_duty <= {PWM_BITS{1'b0}};
            r_pwm  <= 1'b0;
        end else begin
            r_lvl  <= w_lvl_nxt;
            r_duty <= i_period_end ? r_lvl : r_duty;
            r_pwm  <= (i_pwm_cnt < r_duty);
        end
    end

    assign o_lvl = r_lvl;
    assign o_pwm = r_pwm;

endmodule : led_fade_channel

// File: rtl/led_fade_pwm.sv
// LED output stage: fades three on/off requests into PWM drive with a shared counter and step prescaler.
module led_fade_pwm
    import led_fade_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int STEP_DIV = 39062
) (
    input  logic                clk,
    input  logic                reest,
    input  logic                led1_in,
    input  logic                led2_in,
    input  logic                led3_in,
    input  logic [PWM_BITS-1:0] max_level,
    input  logic                fade_en,
    output logic                pwm1,
    output logic                pwm2,
    output logic                pwm3,
    output logic                busy
);

    localparam int PS_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_DIV - 1);

    logic [PWM_BITS-1:0]               r_pwm_cnt;
    logic [PS_W-1:0]                   r_presc;
    logic                              r_busy;
    logic                              w_step_tick;
    logic                              w_period_end;
    logic [NUM_LED-1:0]                w_led;
    logic [NUM_LED-1:0][PWM_BITS-1:0]  w_target;
    logic [NUM_LED-1:0][PWM_BITS-1:0]  w_lvl;
    logic [NUM_LED-1:0]                w_pwm;
    logic [NUM_LED-1:0]                w_mismatch;

    assign w_step_tick  = (r_presc == PS_LAST);
    assign w_period_end = (r_pwm_cnt == {PWM_BITS{1'b1}});
    assign w_led        = {led3_in, led2_in, led1_in};

    // Free-running PWM counter and step prescaler.
    always_ff @(posedge clk) begin
        if (reest) begin
            r_pwm_cnt <= {PWM_BITS{1'b0}};
            r_presc   <= {PS_W{1'b0}};
        end else begin
            r_pwm_cnt <= r_pwm_cnt + {{(PWM_BITS-1){1'b0}}, 1'b1};
            r_presc   <= w_step_tick ? {PS_W{1'b0}} : (r_presc + {{(PS_W-1){1'b0}}, 1'b1});
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_LED; g++) begin : g_ch
            assign w_target[g]   = w_led[g] ? max_level : {PWM_BITS{1'b0}};
            assign w_mismatch[g] = (w_lvl[g] != w_target[g]);

            led_fade_channel #(
                .PWM_BITS (PWM_BITS)
            ) u_ch (
                .clk          (clk),
                .reest        (reest),
                .i_pwm_cnt    (r_pwm_cnt),
                .i_step_tick  (w_step_tick),
                .i_period_end (w_period_end),
                .i_target     (w_target[g]),
                .i_fade_en    (fade_en),
                .o_lvl        (w_lvl[g]),
                .o_pwm        (w_pwm[g])
            );
        end
    endgenerate

    // Busy flag: any channel still away from its target.
    always_ff @(posedge clk) begin
        if (reest) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= |w_mismatch;
        end
    end

    assign pwm1 = w_pwm[0];
    assign pwm2 = w_pwm[1];
    assign pwm3 = w_pwm[2];
    assign busy = r_busy;

endmodule : led_fade_pwm
